// File: rtl/ram_master.sv
// ram_master: initiator-side controller for the single-port synchronous RAM.
//
// Takes single or burst read/write commands over a valid/ready front end,
// streams write beats straight into the RAM and returns read beats through
// a registered, backpressured output.
//
// Handshake rule used on every channel here (cmd, wr, rd): a transfer
// happens at a rising edge where valid && ready are both high; a source
// holds its payload stable while valid is high and ready is low, and ready
// never depends on anything but the state of the receiving side.
//
// Optional build macro: RAM_MASTER_ADDR_CHECK_EN
//   Adds a sticky err output. A command whose start address is >= DEPTH is
//   accepted but performs no RAM access; err is set at the acceptance edge
//   and the controller stays idle. Without the macro, out-of-range start
//   addresses are used as-is and wrap like any other address.
//
// The FSM state is exported on dbg_state for checkers and waveform reading.

module ram_master #(
    parameter int ADDRESS = 3,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDRESS-1:0] cmd_addr,
    input  logic [ADDRESS-1:0] cmd_len,

    input  logic [WIDTH-1:0]   wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,

    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,

    output logic               busy,

    output logic               RdEn,
    output logic               WrEn,
    output logic [ADDRESS-1:0] Address,
    output logic [WIDTH-1:0]   WrData,
    input  logic [WIDTH-1:0]   RdData,

`ifdef RAM_MASTER_ADDR_CHECK_EN
    output logic               err,
`endif
    output logic [2:0]         dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] RD_REQ  = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_OUT  = 3'd4;

    // Highest legal RAM address; the word after it is address 0.
    localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(DEPTH - 1);

    logic [2:0]         state;
    logic [ADDRESS-1:0] addr_q;
    logic [ADDRESS-1:0] cnt_q;
    logic [ADDRESS-1:0] len_q;
    logic [ADDRESS-1:0] addr_nxt;
    logic               cmd_fire;
    logic               wr_fire;
    logic               last_beat;
    logic               start_ok;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign last_beat = (cnt_q == len_q);
    assign addr_nxt  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRESS'(1);

`ifdef RAM_MASTER_ADDR_CHECK_EN
    assign start_ok = ({1'b0, cmd_addr} < (ADDRESS + 1)'(DEPTH));
`else
    assign start_ok = 1'b1;
`endif

    // The RAM address is the burst pointer itself, so it only moves when a
    // burst starts or advances (entering WR/RD_REQ) and on reset.
    assign Address   = addr_q;
    assign dbg_state = state;

    // Handshake and RAM strobes decoded from state; everything is forced
    // quiet during a reset cycle so an abandoned burst issues no access.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        wr_ready  = 1'b0;
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        WrData    = '0;
        if (!rst) begin
            cmd_ready = (state == IDLE);
            busy      = (state != IDLE);
            wr_ready  = (state == WR);
            WrEn      = (state == WR) && wr_valid;
            RdEn      = (state == RD_REQ);
            if (state == WR) begin
                WrData = wr_data;
            end
        end
    end

    // Burst sequencing: command latch, beat counting, address wrap and the
    // registered read-return stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
`ifdef RAM_MASTER_ADDR_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (start_ok) begin
                            addr_q <= cmd_addr;
                            len_q  <= cmd_len;
                            cnt_q  <= '0;
                            state  <= cmd_write ? WR : RD_REQ;
                        end
`ifdef RAM_MASTER_ADDR_CHECK_EN
                        else begin
                            err <= 1'b1;
                        end
`endif
                    end
                end

                WR: begin
                    if (wr_fire) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= addr_nxt;
                            cnt_q  <= cnt_q + ADDRESS'(1);
                        end
                    end
                end

                RD_REQ: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    // RAM data for the request issued last cycle is on RdData now.
                    rd_data  <= RdData;
                    rd_valid <= 1'b1;
                    state    <= RD_OUT;
                end

                RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= addr_nxt;
                            cnt_q  <= cnt_q + ADDRESS'(1);
                            state  <= RD_REQ;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM port can only do one thing per cycle.
    a_en_exclusive: assert property (@(posedge clk) disable iff (rst) !(RdEn && WrEn));

    // A read beat is presented exactly while the FSM is waiting to hand it off.
    a_rd_valid_state: assert property (@(posedge clk) disable iff (rst) rd_valid == (state == RD_OUT));

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed bench for ram_master with a RAM model, a
// word-level memory model and a per-cycle compare process.
`timescale 1ns/1ps

module tb_ram_master;

    localparam int ADDRESS = 3;
    localparam int DEPTH   = 8;
    localparam int WIDTH   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_write = 1'b0;
    logic [ADDRESS-1:0] cmd_addr  = '0;
    logic [ADDRESS-1:0] cmd_len   = '0;
    logic [WIDTH-1:0]   wr_data   = '0;
    logic               wr_valid  = 1'b0;
    logic               wr_ready;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_ready  = 1'b1;
    logic               busy;
    logic               RdEn;
    logic               WrEn;
    logic [ADDRESS-1:0] Address;
    logic [WIDTH-1:0]   WrData;
    logic [WIDTH-1:0]   RdData    = '0;
    logic [2:0]         dbg_state;
`ifdef RAM_MASTER_ADDR_CHECK_EN
    logic               err;
`endif

    ram_master #(.ADDRESS(ADDRESS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy),
        .RdEn(RdEn), .WrEn(WrEn), .Address(Address), .WrData(WrData), .RdData(RdData),
`ifdef RAM_MASTER_ADDR_CHECK_EN
        .err(err),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- RAM model: registered read, data held between reads ----------------
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0]   shadow [0:DEPTH-1];   // what the RAM must hold
    logic [WIDTH-1:0]   wdat   [0:7];         // beat data for the next write
    logic [ADDRESS-1:0] exp_wa_q[$];
    logic [WIDTH-1:0]   exp_wd_q[$];
    logic [ADDRESS-1:0] exp_ra_q[$];
    logic [WIDTH-1:0]   exp_rd_q[$];

    logic [ADDRESS-1:0] wa_log [0:15];
    logic [WIDTH-1:0]   rd_log [0:15];
    int wlog_n = 0;
    int rlog_n = 0;
    int re_n   = 0;
    int acc_cyc = 0;
    int acc_waits = 0;
    int first_wr_cyc = -1;
    int first_re_cyc = -1;
    int first_rv_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address of beat i of a burst starting at a.
    function automatic logic [ADDRESS-1:0] beat_addr(input int a, input int i);
        return ADDRESS'((a + i) % DEPTH);
    endfunction

    // ---------------- compare process ----------------
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;

    always @(negedge clk) begin : cmp
        logic [ADDRESS-1:0] ea;
        logic [WIDTH-1:0]   ed;
        if (!rst) begin
            if (RdEn || WrEn) chk("rd_wr_exclusive", 32'(RdEn && WrEn), 0);
            if (WrEn) begin
                if (exp_wa_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    ea = exp_wa_q.pop_front();
                    ed = exp_wd_q.pop_front();
                    chk("wr_addr", 32'(Address), 32'(ea));
                    chk("wr_data", 32'(WrData), 32'(ed));
                end
                if (wlog_n < 16) wa_log[wlog_n] = Address;
                wlog_n++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (RdEn) begin
                re_n++;
                if (exp_ra_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    ea = exp_ra_q.pop_front();
                    chk("rd_addr", 32'(Address), 32'(ea));
                end
                chk("no_rden_while_beat_pending", 32'(rd_valid), 0);
                if (first_re_cyc < 0) first_re_cyc = cyc;
            end
            if (stall_prev) begin
                chk("stall_rd_valid_held", 32'(rd_valid), 1);
                chk("stall_rd_data_held", 32'(rd_data), 32'(held));
            end
            if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_rd_beat", 1, 0);
                end else begin
                    ed = exp_rd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(ed));
                end
                if (rlog_n < 16) rd_log[rlog_n] = rd_data;
                rlog_n++;
            end
            stall_prev = rd_valid && !rd_ready;
            held       = rd_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Hold the command until it is taken; records how many cycles it waited.
    task automatic wait_accept(input string name);
        logic ok;
        acc_waits = 0;
        do begin
            @(negedge clk);
            ok = cmd_ready;
            acc_waits++;
            if (ok) chk({name, "_no_beat_in_accept"}, 32'({WrEn, wr_ready}), 0);
            @(posedge clk); #1;
        end while (!ok && acc_waits < 20);
        if (!ok) chk({name, "_accept_timeout"}, 0, 1);
        acc_cyc = cyc;
    endtask

    task automatic do_write(input int a, input int l, input int gap_after);
        logic ok;
        int   n;
        for (int i = 0; i <= l; i++) begin
            exp_wa_q.push_back(beat_addr(a, i));
            exp_wd_q.push_back(wdat[i]);
            shadow[beat_addr(a, i)] = wdat[i];
        end
        first_wr_cyc = -1;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = ADDRESS'(a); cmd_len = ADDRESS'(l);
        wr_valid = 1'b1; wr_data = wdat[0];
        wait_accept("wr_cmd");
        cmd_valid = 1'b0;
        for (int i = 0; i <= l; i++) begin
            wr_valid = 1'b1; wr_data = wdat[i];
            n = 0;
            do begin
                @(negedge clk); ok = wr_ready; n++;
                @(posedge clk); #1;
            end while (!ok && n < 20);
            if (!ok) chk("wr_beat_timeout", 0, 1);
            if (i == gap_after) begin
                wr_valid = 1'b0;
                @(negedge clk);
                chk("wr_gap_no_wren", 32'(WrEn), 0);
                chk("wr_gap_still_ready", 32'(wr_ready), 1);
                @(posedge clk); #1;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rd_valid && n < 20);
        if (!rd_valid) chk({name, "_rd_valid_timeout"}, 0, 1);
    endtask

    // Read burst; the beat numbered stall_beat is held off for two cycles.
    task automatic do_read(input int a, input int l, input int stall_beat);
        for (int i = 0; i <= l; i++) begin
            exp_ra_q.push_back(beat_addr(a, i));
            exp_rd_q.push_back(shadow[beat_addr(a, i)]);
        end
        first_re_cyc = -1; first_rv_cyc = -1;
        cmd_valid = 1'b1; cmd_write = 1'b0;
        cmd_addr = ADDRESS'(a); cmd_len = ADDRESS'(l);
        rd_ready = (stall_beat != 0);
        wait_accept("rd_cmd");
        cmd_valid = 1'b0;
        for (int i = 0; i <= l; i++) begin
            wait_rd_valid("rd_beat");
            if (!rd_ready) begin
                @(posedge clk); #1;
                @(negedge clk);
                @(posedge clk); #1;
                rd_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk); #1;
            rd_ready = (i + 1 != stall_beat);
        end
        rd_ready = 1'b1;
    endtask

`ifdef RAM_MASTER_ADDR_CHECK_EN
    // Second instance with a RAM smaller than the address space.
    logic               c_cmd_valid = 1'b0;
    logic               c_cmd_write = 1'b0;
    logic [ADDRESS-1:0] c_cmd_addr  = '0;
    logic [ADDRESS-1:0] c_cmd_len   = '0;
    logic [WIDTH-1:0]   c_wr_data   = '0;
    logic               c_wr_valid  = 1'b0;
    logic               c_cmd_ready, c_wr_ready, c_rd_valid, c_busy, c_RdEn, c_WrEn, c_err;
    logic [WIDTH-1:0]   c_rd_data, c_WrData;
    logic [ADDRESS-1:0] c_Address;
    logic [2:0]         c_dbg;

    ram_master #(.ADDRESS(ADDRESS), .DEPTH(6), .WIDTH(WIDTH)) u_chk (
        .clk(clk), .rst(rst),
        .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready), .cmd_write(c_cmd_write),
        .cmd_addr(c_cmd_addr), .cmd_len(c_cmd_len),
        .wr_data(c_wr_data), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_ready(1'b1),
        .busy(c_busy),
        .RdEn(c_RdEn), .WrEn(c_WrEn), .Address(c_Address), .WrData(c_WrData), .RdData(16'h0000),
        .err(c_err),
        .dbg_state(c_dbg)
    );
`endif

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end

        // Power-up reset, a few idle cycles, then a 2-cycle reset mid-idle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_rden", 32'(RdEn), 0);
            chk("rst_wren", 32'(WrEn), 0);
            chk("rst_busy", 32'(busy), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rd_valid", 32'(rd_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_rd_data", 32'(rd_data), 0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_address", 32'(Address), 0);
        @(posedge clk); #1;

        // Single write at 5 with wr_valid already high in the accept cycle.
        wlog_n = 0;
        wdat[0] = 16'hA5A5;
        do_write(5, 0, -1);
        chk("single_wr_first_wren_cycle_after_accept", 32'(first_wr_cyc - acc_cyc), 0);
        @(negedge clk);
        chk("single_wr_busy_dropped", 32'(busy), 0);
        chk("single_wr_one_wren", 32'(wlog_n), 1);
        chk("single_wr_addr_lit", 32'(wa_log[0]), 5);
        @(posedge clk); #1;

        // Burst write 6..1 with a one-cycle wr_valid gap after beat 2.
        wlog_n = 0;
        wdat[0] = 16'd1; wdat[1] = 16'd2; wdat[2] = 16'd3; wdat[3] = 16'd4;
        do_write(6, 3, 1);
        chk("burst_wr_beats", 32'(wlog_n), 4);
        chk("burst_wr_addr0_lit", 32'(wa_log[0]), 6);
        chk("burst_wr_addr1_lit", 32'(wa_log[1]), 7);
        chk("burst_wr_addr2_lit", 32'(wa_log[2]), 0);
        chk("burst_wr_addr3_lit", 32'(wa_log[3]), 1);

        // Burst read 6..1, beat 2 stalled for two cycles.
        rlog_n = 0; re_n = 0;
        do_read(6, 3, 1);
        chk("rd_first_rden_in_accept_cycle", 32'(first_re_cyc - acc_cyc), 0);
        chk("rd_first_valid_at_e2", 32'(first_rv_cyc - acc_cyc), 2);
        chk("rd_one_rden_per_beat", 32'(re_n), 4);
        chk("rd_beats", 32'(rlog_n), 4);
        chk("rd_data0_lit", 32'(rd_log[0]), 16'd1);
        chk("rd_data1_lit", 32'(rd_log[1]), 16'd2);
        chk("rd_data2_lit", 32'(rd_log[2]), 16'd3);
        chk("rd_data3_lit", 32'(rd_log[3]), 16'd4);

        // Single read of the first write.
        rlog_n = 0;
        do_read(5, 0, -1);
        chk("single_rd_lit", 32'(rd_log[0]), 16'hA5A5);

        // Back-to-back: write then read, read taken the cycle after idle.
        wdat[0] = 16'h1111; wdat[1] = 16'h2222;
        do_write(2, 1, -1);
        rlog_n = 0;
        do_read(2, 1, -1);
        chk("b2b_accept_next_cycle", 32'(acc_waits), 1);
        chk("b2b_rd0_lit", 32'(rd_log[0]), 16'h1111);
        chk("b2b_rd1_lit", 32'(rd_log[1]), 16'h2222);

        // Reset while beat 2 of a 4-beat read waits in the output stage.
        for (int i = 0; i <= 3; i++) begin
            exp_ra_q.push_back(beat_addr(0, i));
            exp_rd_q.push_back(shadow[beat_addr(0, i)]);
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 3'd3;
        rd_ready = 1'b1;
        wait_accept("rst_rd_cmd");
        cmd_valid = 1'b0;
        wait_rd_valid("rst_rd_beat0");
        @(posedge clk); #1;
        rd_ready = 1'b0;
        wait_rd_valid("rst_rd_beat1");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rden", 32'(RdEn), 0);
        chk("midrst_wren", 32'(WrEn), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ra_q.delete(); exp_rd_q.delete();
        @(negedge clk);
        chk("midrst_after_rd_valid", 32'(rd_valid), 0);
        chk("midrst_after_busy", 32'(busy), 0);
        chk("midrst_after_rden", 32'(RdEn), 0);
        chk("midrst_after_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_after_rd_data", 32'(rd_data), 0);
        re_n = 0; wlog_n = 0;
        repeat (6) @(negedge clk);
        chk("midrst_no_further_access", 32'(re_n + wlog_n), 0);
        rd_ready = 1'b1;
        @(posedge clk); #1;

`ifdef RAM_MASTER_ADDR_CHECK_EN
        chk("err_clear_in_range", 32'(err), 0);
        // Out-of-range start on a 6-word RAM: handshake completes, nothing else.
        c_cmd_valid = 1'b1; c_cmd_write = 1'b1; c_cmd_addr = 3'd7; c_cmd_len = 3'd0;
        c_wr_valid = 1'b1; c_wr_data = 16'hDEAD;
        @(negedge clk);
        chk("chk_bad_cmd_ready", 32'(c_cmd_ready), 1);
        @(posedge clk); #1;
        c_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("chk_bad_err", 32'(c_err), 1);
            chk("chk_bad_no_wren", 32'(c_WrEn), 0);
            chk("chk_bad_no_wr_ready", 32'(c_wr_ready), 0);
            chk("chk_bad_idle", 32'(c_busy), 0);
            @(posedge clk); #1;
        end
        c_wr_valid = 1'b0;
        // Valid write at 5, two beats: wraps to 0 on the 6-word RAM.
        c_cmd_valid = 1'b1; c_cmd_addr = 3'd5; c_cmd_len = 3'd1;
        @(negedge clk);
        chk("chk_good_cmd_ready", 32'(c_cmd_ready), 1);
        @(posedge clk); #1;
        c_cmd_valid = 1'b0;
        c_wr_valid = 1'b1; c_wr_data = 16'h0055;
        @(negedge clk);
        chk("chk_good_wren0", 32'(c_WrEn), 1);
        chk("chk_good_addr0", 32'(c_Address), 5);
        @(posedge clk); #1;
        c_wr_data = 16'h00AA;
        @(negedge clk);
        chk("chk_good_wren1", 32'(c_WrEn), 1);
        chk("chk_good_addr1_wrap", 32'(c_Address), 0);
        chk("chk_good_data1", 32'(c_WrData), 16'h00AA);
        @(posedge clk); #1;
        c_wr_valid = 1'b0;
        @(negedge clk);
        chk("chk_good_done", 32'(c_busy), 0);
        chk("chk_err_sticky", 32'(c_err), 1);
        @(posedge clk); #1;
`endif

        // Every expected access must have been seen.
        chk("wr_queue_drained", 32'(exp_wa_q.size()), 0);
        chk("rd_addr_queue_drained", 32'(exp_ra_q.size()), 0);
        chk("rd_data_queue_drained", 32'(exp_rd_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop if a handshake never completes despite the bounded waits.
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
